lamp_mode_controller: RTL and testbench
=======================================

# lamp_mode_controller

Top-level sequencing FSM of the lamp controller. Classifies the push button into short and long presses and owns the auto/manual mode and lamp state. Drives the enable of the auto-shutdown timer and consumes that timer's one-cycle timeout pulse. All timing assumes clk = 1 kHz (1 cycle = 1 ms).

## Interface
Parameters:
- MIN_PRESS_T, 100, minimum high cycles for a valid press; shorter pulses are glitches.
- LONG_PRESS_T, 3000, high cycles at which a hold becomes a long press; must be > MIN_PRESS_T.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  push button, active-high, already synchronised to clk.
- infra  in  1  presence sensor, 1 = presence.
- C  in  1  auto-shutdown timeout pulse from the timer, one cycle wide.
- L  out  1  lamp drive, 1 = on.
- timer_en  out  1  enable to the auto-shutdown timer.
- manual  out  1  mode indicator, 1 = manual.

## Operation
- Press classifier: counter Tp of width $clog2(LONG_PRESS_T+1); counts cycles with push=1 and saturates at LONG_PRESS_T.
- Armed flag: cleared by reset, set on the first cycle push=0. Tp counts only while armed, so a button held through reset is ignored until it is released.
- Long-press event: one cycle, on the edge where Tp reaches LONG_PRESS_T. At most one per hold.
- Short-press event: one cycle, on the release edge (push 1→0) when MIN_PRESS_T ≤ Tp < LONG_PRESS_T.
- Glitch: release with Tp < MIN_PRESS_T produces no event. Release after a long press produces no event.
- Tp clears to 0 on every release.
- Mode FSM states: AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON.
- Transitions from AUTO_OFF: long → MANUAL_OFF; otherwise infra=1 → AUTO_ON.
- Transitions from AUTO_ON: long → MANUAL_OFF; otherwise C=1 → AUTO_OFF.
- Short press is ignored in both AUTO states.
- Transitions from MANUAL_OFF / MANUAL_ON: long → AUTO_OFF; short toggles MANUAL_OFF ↔ MANUAL_ON. infra is ignored in manual.
- Same-cycle priority: long > C > short > infra.
- Outputs (Moore): L = state ∈ {AUTO_ON, MANUAL_ON}; manual = state ∈ {MANUAL_OFF, MANUAL_ON}; timer_en = (state == AUTO_ON).

## Timing
- Reset values: state = AUTO_OFF, Tp = 0, armed = 0. Therefore L = 0, timer_en = 0, manual = 0.
- infra=1 sampled at edge n in AUTO_OFF → L = 1 and timer_en = 1 after edge n.
- C sampled at edge n in AUTO_ON → L = 0 and timer_en = 0 after edge n.
- Long press: push rises before edge k → mode changes after edge k+LONG_PRESS_T−1, i.e. the LONG_PRESS_T-th high sample.
- Short press: state change after the first edge that samples push=0.
- Reset mid-hold or mid-on: immediate return to reset values; no event is emitted on the subsequent release.

## Configuration
- MANUAL_SHUTDOWN_EN defined: timer_en is also 1 in MANUAL_ON, and C=1 in MANUAL_ON → MANUAL_OFF. Priority is unchanged: long > C > short.
- MANUAL_SHUTDOWN_EN undefined: manual-on lamp stays on indefinitely, and C is ignored outside AUTO_ON.

## Structure
- Package lamp_ctrl_pkg holds:
  - state enum lamp_state_t (AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON);
  - press event enum press_evt_t (NONE, SHORT, LONG);
  - the cycles-per-ms constant.
- Sub-module push_classifier (clk, rst, push → press_evt_t) contains Tp, the armed flag and the event logic. The mode FSM lives in lamp_mode_controller.

## Test plan
- Reset, then infra=1 for 1 cycle → L=1 and timer_en=1 next cycle. Pulse C → L=0 next cycle.
- Push high for 3000 cycles → manual=1 and L=0 after the 3000th high sample. Release → no further change.
- In manual, push high for 500 cycles then release → L=1. Repeat → L=0. A 50-cycle pulse → no change.
- In manual, infra=1 and C pulses → L unchanged (MANUAL_SHUTDOWN_EN undefined). With the macro defined: MANUAL_ON plus C → L=0 and timer_en=0.
- In AUTO_ON, C pulse in the same cycle as the long-press event → state MANUAL_OFF, not AUTO_OFF.
- Assert rst while push is held at cycle 2000. Release rst with push still high for 5000 cycles → no event and manual stays 0.

Source files
------------

// File: rtl/lamp_mode_controller_pkg.sv
// Shared types and constants for the lamp controller.
// The optional MANUAL_SHUTDOWN_EN build macro is consumed by lamp_mode_controller.
package lamp_ctrl_pkg;

    // One clock cycle per millisecond at the 1 kHz system clock.
    localparam int CYCLES_PER_MS = 1;

    typedef enum logic [1:0] {
        AUTO_OFF,
        AUTO_ON,
        MANUAL_OFF,
        MANUAL_ON
    } lamp_state_t;

    typedef enum logic [1:0] {
        NONE,
        SHORT,
        LONG
    } press_evt_t;

endpackage

// File: rtl/lamp_mode_controller_push_classifier.sv
// Push-button classifier: measures how long the button is held and emits a
// one-cycle SHORT event on release or a one-cycle LONG event while held.
// A button already held when reset is released is ignored until it is let go.
module push_classifier
    import lamp_ctrl_pkg::*;
#(
    parameter int MIN_PRESS_T  = 100,
    parameter int LONG_PRESS_T = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    output press_evt_t evt
);

    localparam int TP_W = $clog2(LONG_PRESS_T + 1);
    localparam logic [TP_W-1:0] MIN_TP       = TP_W'(MIN_PRESS_T);
    localparam logic [TP_W-1:0] LONG_TP      = TP_W'(LONG_PRESS_T);
    localparam logic [TP_W-1:0] LONG_TP_LAST = TP_W'(LONG_PRESS_T - 1);

    logic [TP_W-1:0] tp;
    logic            armed;

    // Hold-time counter, saturating at LONG_PRESS_T; cleared on every release.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (rst) begin
            tp    <= '0;
            armed <= 1'b0;
        end else if (!push) begin
            armed <= 1'b1;
            tp    <= '0;
        end else if (armed && tp != LONG_TP) begin
            tp <= tp + 1'b1;
        end
    end

    // Event decode: LONG on the sample that brings tp to LONG_PRESS_T,
    // SHORT on the first low sample after a hold of valid length.
    always_comb begin
        // NOTE: default assigned first so no path leaves evt unassigned (no latch).
        evt = NONE;
        if (armed) begin
            if (push && tp == LONG_TP_LAST) begin
                evt = LONG;
            end else if (!push && tp >= MIN_TP && tp < LONG_TP) begin
                evt = SHORT;
            end
        end
    end

endmodule

// File: rtl/lamp_mode_controller.sv
// Lamp mode controller: auto/manual mode FSM driven by classified button
// presses, the presence sensor and the auto-shutdown timer timeout.
// Build macro MANUAL_SHUTDOWN_EN: when defined, the auto-shutdown timer also
// runs in MANUAL_ON and its timeout turns the manual lamp off.
module lamp_mode_controller
    import lamp_ctrl_pkg::*;
#(
    parameter int MIN_PRESS_T  = 100,
    parameter int LONG_PRESS_T = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic infra,
    input  logic C,
    output logic L,
    output logic timer_en,
    output logic manual
);

    press_evt_t  evt;
    lamp_state_t state;
    lamp_state_t state_nxt;

    push_classifier #(
        .MIN_PRESS_T (MIN_PRESS_T),
        .LONG_PRESS_T(LONG_PRESS_T)
    ) u_push_classifier (
        .clk (clk),
        .rst (rst),
        .push(push),
        .evt (evt)
    );

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= AUTO_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic (priority long > C > short > infra) and Moore outputs.
    always_comb begin
        state_nxt = state;
        L         = 1'b0;
        manual    = 1'b0;
        timer_en  = 1'b0;

        unique case (state)
            AUTO_OFF: begin
                if (evt == LONG)  state_nxt = MANUAL_OFF;
                else if (infra)   state_nxt = AUTO_ON;
            end
            AUTO_ON: begin
                L        = 1'b1;
                timer_en = 1'b1;
                if (evt == LONG)  state_nxt = MANUAL_OFF;
                else if (C)       state_nxt = AUTO_OFF;
            end
            MANUAL_OFF: begin
                manual = 1'b1;
                if (evt == LONG)       state_nxt = AUTO_OFF;
                else if (evt == SHORT) state_nxt = MANUAL_ON;
            end
            MANUAL_ON: begin
                L      = 1'b1;
                manual = 1'b1;
`ifdef MANUAL_SHUTDOWN_EN
                timer_en = 1'b1;
                if (evt == LONG)       state_nxt = AUTO_OFF;
                else if (C)            state_nxt = MANUAL_OFF;
                else if (evt == SHORT) state_nxt = MANUAL_OFF;
`else
                if (evt == LONG)       state_nxt = AUTO_OFF;
                else if (evt == SHORT) state_nxt = MANUAL_OFF;
`endif
            end
            default: state_nxt = AUTO_OFF;
        endcase
    end

endmodule

// File: tb/tb_lamp_mode_controller.sv
// Self-checking bench for lamp_mode_controller: directed scenarios followed by
// randomized button/sensor/timeout traffic, all compared against a
// behavioural model of hold durations and lamp/mode bits.
module tb_lamp_mode_controller;

    localparam int MIN_T  = 100;
    localparam int LONG_T = 3000;
`ifdef MANUAL_SHUTDOWN_EN
    localparam bit MSE_ON = 1'b1;
`else
    localparam bit MSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push = 1'b0;
    logic infra = 1'b0;
    logic C = 1'b0;
    logic L;
    logic timer_en;
    logic manual;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: hold length of the current press, arming, mode and lamp.
    int m_hold;
    bit m_armed;
    bit m_manual;
    bit m_lamp;

    lamp_mode_controller #(
        .MIN_PRESS_T (MIN_T),
        .LONG_PRESS_T(LONG_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .infra   (infra),
        .C       (C),
        .L       (L),
        .timer_en(timer_en),
        .manual  (manual)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_hold   = 0;
        m_armed  = 1'b0;
        m_manual = 1'b0;
        m_lamp   = 1'b0;
    endtask

    // One clock edge of the behavioural model with the inputs sampled there.
    task automatic model_edge(input logic p, input logic i, input logic c);
        bit lng;
        bit sht;
        lng = 1'b0;
        sht = 1'b0;
        if (!m_armed) begin
            if (!p) m_armed = 1'b1;
            m_hold = 0;
        end else if (p) begin
            if (m_hold < LONG_T) begin
                m_hold++;
                lng = (m_hold == LONG_T);
            end
        end else begin
            sht    = (m_hold >= MIN_T) && (m_hold < LONG_T);
            m_hold = 0;
        end

        if (lng) begin
            m_manual = !m_manual;
            m_lamp   = 1'b0;
        end else if (!m_manual) begin
            if (m_lamp) begin
                if (c) m_lamp = 1'b0;
            end else if (i) begin
                m_lamp = 1'b1;
            end
        end else if (MSE_ON && m_lamp && c) begin
            m_lamp = 1'b0;
        end else if (sht) begin
            m_lamp = !m_lamp;
        end
    endtask

    function automatic logic [2:0] model_outs();
        return {m_lamp, m_manual, m_lamp && (!m_manual || MSE_ON)};
    endfunction

    // Called at a falling edge: drive inputs, let the rising edge sample them,
    // compare just after it, and return at the next falling edge.
    task automatic step(input logic p, input logic i, input logic c);
        push  = p;
        infra = i;
        C     = c;
        @(posedge clk);
        model_edge(p, i, c);
        #1;
        check("outs", {L, manual, timer_en}, model_outs());
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic p);
        for (int k = 0; k < n; k++) step(p, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released at the next falling edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_outs", {L, manual, timer_en}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int cat;
        int rst_at;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {L, manual, timer_en}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        // Arm, then presence turns the lamp on, timeout turns it off.
        hold(3, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("infra_on", {L, timer_en}, 2'b11);
        hold(5, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("c_off", {L, timer_en}, 2'b00);

        // Long press: no change after 2999 high samples, manual after 3000.
        hold(LONG_T - 1, 1'b1);
        check("long_minus1", manual, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("long_manual", {manual, L}, 2'b10);
        hold(3, 1'b0);
        check("long_release", {manual, L}, 2'b10);

        // Short presses toggle, glitches and a 99-cycle press do not.
        hold(500, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("short_on", L, 1'b1);
        hold(500, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("short_off", L, 1'b0);
        hold(50, 1'b1);
        hold(2, 1'b0);
        check("glitch", L, 1'b0);
        hold(MIN_T - 1, 1'b1);
        hold(2, 1'b0);
        check("min_minus1", L, 1'b0);
        hold(MIN_T, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("min_exact", L, 1'b1);

        // Presence and timeout while manual-on.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("manual_c", {L, timer_en}, MSE_ON ? 2'b00 : 2'b10);

        // Back to auto, lamp on by presence, then long press coinciding with C.
        hold(LONG_T, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("back_auto", manual, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("auto_on2", L, 1'b1);
        hold(LONG_T - 1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("long_vs_c", {manual, L}, 2'b10);
        step(1'b0, 1'b0, 1'b0);

        // Manual-on, then reset in the middle of a 2000-cycle hold.
        hold(300, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("pre_rst_on", {manual, L}, 2'b11);
        push = 1'b1;
        hold(2000, 1'b1);
        async_reset();
        hold(5000, 1'b1);
        check("held_thru_rst", {manual, L}, 2'b00);
        step(1'b0, 1'b0, 1'b0);
        check("release_after_rst", {manual, L}, 2'b00);

        // Randomized traffic.
        for (int seg = 0; seg < 30; seg++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++)
                step(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            cat = $urandom_range(0, 3);
            case (cat)
                0:       len = $urandom_range(1, 150);
                1:       len = $urandom_range(95, 105);
                2:       len = $urandom_range(200, 800);
                default: len = $urandom_range(LONG_T - 5, LONG_T + 5);
            endcase
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                if (k == rst_at) begin
                    push = 1'b1;
                    async_reset();
                end
                step(1'b1, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            end
        end
        hold(3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
